// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU.
// Holds decoded operands and control for the instruction in EX. It resolves
// operand forwarding from EX/MEM and MEM/WB, and raises load_use when the
// instruction in decode depends on a load that is currently in EX.
module alu_issue_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dec_valid,
  input  logic [REG_W-1:0]  dec_rs,
  input  logic [REG_W-1:0]  dec_rt,
  input  logic [WORD_W-1:0] dec_rdat1,
  input  logic [WORD_W-1:0] dec_rdat2,
  input  logic [WORD_W-1:0] dec_imm,
  input  logic              dec_alusrc,
  input  logic [OP_W-1:0]   dec_aluop,
  input  logic [REG_W-1:0]  dec_wsel,
  input  logic              dec_regwen,
  input  logic              dec_memren,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_regwen,
  input  logic [REG_W-1:0]  exmem_wsel,
  input  logic [WORD_W-1:0] exmem_result,
  input  logic              memwb_regwen,
  input  logic [REG_W-1:0]  memwb_wsel,
  input  logic [WORD_W-1:0] memwb_wdat,
  output logic [WORD_W-1:0] portA,
  output logic [WORD_W-1:0] portB,
  output logic [OP_W-1:0]   aluop,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_wsel,
  output logic              ex_regwen,
  output logic              ex_memren,
  output logic              load_use
);

  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [WORD_W-1:0] ex_rdat1;
  logic [WORD_W-1:0] ex_rdat2;
  logic [WORD_W-1:0] ex_imm;
  logic              ex_alusrc;
  logic [OP_W-1:0]   ex_aluop;
  logic [WORD_W-1:0] fwd_a;
  logic [WORD_W-1:0] fwd_b;

  // Operand A forwarding: EX/MEM beats MEM/WB, and r0 is never forwarded.
  always_comb begin
    fwd_a = ex_rdat1;
    if (exmem_regwen && (exmem_wsel == ex_rs) && (ex_rs != '0))
      fwd_a = exmem_result;
    else if (memwb_regwen && (memwb_wsel == ex_rs) && (ex_rs != '0))
      fwd_a = memwb_wdat;
  end

  // Operand B (register path) forwarding, using the same priority as A.
  always_comb begin
    fwd_b = ex_rdat2;
    if (exmem_regwen && (exmem_wsel == ex_rt) && (ex_rt != '0))
      fwd_b = exmem_result;
    else if (memwb_regwen && (memwb_wsel == ex_rt) && (ex_rt != '0))
      fwd_b = memwb_wdat;
  end

  // ALU operand and opcode outputs.
  // These are driven even for a bubble, because downstream ignores the result.
  always_comb begin
    portA = fwd_a;
    portB = ex_alusrc ? ex_imm : fwd_b;
    aluop = ex_aluop;
  end

  // Load-use detection.
  // This checks rt even when decode will use the immediate, so it is
  // deliberately conservative.
  always_comb begin
    load_use = ex_valid && ex_memren && (ex_wsel != '0) && dec_valid &&
               ((ex_wsel == dec_rs) || (ex_wsel == dec_rt));
  end

  // EX register update. The priority order is flush, then stall, then
  // bubble, then a normal load.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_valid  <= 1'b0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rdat1  <= '0;
      ex_rdat2  <= '0;
      ex_imm    <= '0;
      ex_alusrc <= 1'b0;
      ex_aluop  <= '0;
      ex_wsel   <= '0;
      ex_regwen <= 1'b0;
      ex_memren <= 1'b0;
    end else if (flush) begin
      ex_valid  <= 1'b0;
      ex_regwen <= 1'b0;
      ex_memren <= 1'b0;
    end else if (stall) begin
      // Capture the forwarded values so that a producer retiring during the
      // stall does not take its result with it.
      ex_rdat1 <= fwd_a;
      ex_rdat2 <= fwd_b;
    end else if (load_use) begin
      ex_valid  <= 1'b0;
      ex_regwen <= 1'b0;
      ex_memren <= 1'b0;
    end else begin
      ex_valid  <= dec_valid;
      ex_rs     <= dec_rs;
      ex_rt     <= dec_rt;
      ex_rdat1  <= dec_rdat1;
      ex_rdat2  <= dec_rdat2;
      ex_imm    <= dec_imm;
      ex_alusrc <= dec_alusrc;
      ex_aluop  <= dec_aluop;
      ex_wsel   <= dec_wsel;
      ex_regwen <= dec_regwen & dec_valid;
      ex_memren <= dec_memren & dec_valid;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage.
// The stimulus process pushes hand-computed expectations. A monitor process
// pops each expectation and compares it with the DUT outputs.
module tb_alu_issue_stage;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int OP_W   = 4;

  localparam int ID_PA = 0, ID_PB = 1, ID_OP = 2, ID_VAL = 3;
  localparam int ID_WSEL = 4, ID_RW = 5, ID_MR = 6, ID_LU = 7;

  logic              CLK, nRST;
  logic              dec_valid, dec_alusrc, dec_regwen, dec_memren;
  logic [REG_W-1:0]  dec_rs, dec_rt, dec_wsel;
  logic [WORD_W-1:0] dec_rdat1, dec_rdat2, dec_imm;
  logic [OP_W-1:0]   dec_aluop;
  logic              stall, flush;
  logic              exmem_regwen, memwb_regwen;
  logic [REG_W-1:0]  exmem_wsel, memwb_wsel;
  logic [WORD_W-1:0] exmem_result, memwb_wdat;
  logic [WORD_W-1:0] portA, portB;
  logic [OP_W-1:0]   aluop;
  logic              ex_valid, ex_regwen, ex_memren, load_use;
  logic [REG_W-1:0]  ex_wsel;

  typedef struct {
    int          id;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   n_pass  = 0;
  int   n_total = 0;

  alu_issue_stage #(.WORD_W(WORD_W), .REG_W(REG_W), .OP_W(OP_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rdat1(dec_rdat1), .dec_rdat2(dec_rdat2), .dec_imm(dec_imm),
    .dec_alusrc(dec_alusrc), .dec_aluop(dec_aluop), .dec_wsel(dec_wsel),
    .dec_regwen(dec_regwen), .dec_memren(dec_memren),
    .stall(stall), .flush(flush),
    .exmem_regwen(exmem_regwen), .exmem_wsel(exmem_wsel), .exmem_result(exmem_result),
    .memwb_regwen(memwb_regwen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
    .portA(portA), .portB(portB), .aluop(aluop), .ex_valid(ex_valid),
    .ex_wsel(ex_wsel), .ex_regwen(ex_regwen), .ex_memren(ex_memren),
    .load_use(load_use)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Monitor: pops every pending expectation and compares it with the DUT.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.id)
          ID_PA:   act = portA;
          ID_PB:   act = portB;
          ID_OP:   act = 32'(aluop);
          ID_VAL:  act = 32'(ex_valid);
          ID_WSEL: act = 32'(ex_wsel);
          ID_RW:   act = 32'(ex_regwen);
          ID_MR:   act = 32'(ex_memren);
          default: act = 32'(load_use);
        endcase
        n_total++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic expect_sig(input int id, input logic [31:0] v, input string nm);
    exp_t e;
    e.id = id; e.exp = v; e.name = nm;
    sb.push_back(e);
  endtask

  // Lets combinational logic settle, hands the expectations to the monitor,
  // then leaves it time to finish before inputs change again.
  task automatic probe();
    #1;
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic expect_zero(input string tag);
    expect_sig(ID_PA,   0, {tag, "_portA"});
    expect_sig(ID_PB,   0, {tag, "_portB"});
    expect_sig(ID_OP,   0, {tag, "_aluop"});
    expect_sig(ID_VAL,  0, {tag, "_ex_valid"});
    expect_sig(ID_WSEL, 0, {tag, "_ex_wsel"});
    expect_sig(ID_RW,   0, {tag, "_ex_regwen"});
    expect_sig(ID_MR,   0, {tag, "_ex_memren"});
    expect_sig(ID_LU,   0, {tag, "_load_use"});
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_rdat1 = 0; dec_rdat2 = 0;
    dec_imm = 0; dec_alusrc = 0; dec_aluop = 0; dec_wsel = 0;
    dec_regwen = 0; dec_memren = 0; stall = 0; flush = 0;
    exmem_regwen = 0; exmem_wsel = 0; exmem_result = 0;
    memwb_regwen = 0; memwb_wsel = 0; memwb_wdat = 0;
  endtask

  task automatic dec(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] r1,
                     input logic [31:0] r2, input logic [31:0] imm, input logic src,
                     input logic [3:0] op, input logic [4:0] ws, input logic rw,
                     input logic mr);
    dec_valid = 1; dec_rs = rs; dec_rt = rt; dec_rdat1 = r1; dec_rdat2 = r2;
    dec_imm = imm; dec_alusrc = src; dec_aluop = op; dec_wsel = ws;
    dec_regwen = rw; dec_memren = mr;
  endtask

  initial begin
    nRST = 0;
    idle();
    @(negedge CLK);
    expect_zero("in_reset");
    probe();
    nRST = 1;
    tick();
    expect_zero("after_reset");
    probe();

    // Plain load with no forwarding.
    dec(1, 2, 5, 7, 0, 0, 4'h2, 3, 1, 0);
    tick();
    expect_sig(ID_PA, 5, "basic_portA");
    expect_sig(ID_PB, 7, "basic_portB");
    expect_sig(ID_OP, 2, "basic_aluop");
    expect_sig(ID_VAL, 1, "basic_valid");
    expect_sig(ID_WSEL, 3, "basic_wsel");
    expect_sig(ID_RW, 1, "basic_regwen");
    expect_sig(ID_MR, 0, "basic_memren");
    expect_sig(ID_LU, 0, "basic_load_use");
    probe();

    // Forwarding priority on A and B.
    dec(3, 5, 1, 2, 0, 0, 4'h3, 7, 1, 0);
    tick();
    exmem_regwen = 1; exmem_wsel = 3; exmem_result = 32'hAAAA0000;
    memwb_regwen = 1; memwb_wsel = 3; memwb_wdat = 32'h55;
    expect_sig(ID_PA, 32'hAAAA0000, "fwd_exmem_prio");
    expect_sig(ID_PB, 2, "fwd_b_nomatch");
    probe();
    exmem_wsel = 0;
    expect_sig(ID_PA, 32'h55, "fwd_memwb");
    probe();
    exmem_wsel = 3; exmem_regwen = 0; memwb_wsel = 5;
    expect_sig(ID_PA, 1, "fwd_exmem_regwen_off");
    expect_sig(ID_PB, 32'h55, "fwd_b_memwb");
    probe();
    exmem_regwen = 1; exmem_wsel = 5;
    expect_sig(ID_PB, 32'hAAAA0000, "fwd_b_exmem_prio");
    probe();
    idle();

    // Register 0 is never forwarded, and the immediate bypasses forwarding.
    dec(0, 6, 0, 32'h33, 32'h10, 1, 4'h4, 2, 1, 0);
    tick();
    exmem_regwen = 1; exmem_wsel = 0; exmem_result = 32'hFFFFFFFF;
    memwb_regwen = 1; memwb_wsel = 6; memwb_wdat = 32'h77;
    expect_sig(ID_PA, 0, "r0_no_fwd");
    expect_sig(ID_PB, 32'h10, "imm_over_fwd");
    probe();
    idle();

    // Load-use detection and bubble insertion.
    dec(1, 2, 32'h40, 0, 0, 0, 4'h0, 4, 1, 1);
    tick();
    dec_valid = 0; dec_rs = 4; dec_rt = 9; dec_memren = 0; dec_wsel = 8;
    expect_sig(ID_LU, 0, "lu_dec_invalid");
    probe();
    dec(9, 4, 32'h11, 32'h22, 0, 0, 4'h5, 8, 1, 0);
    expect_sig(ID_LU, 1, "lu_rt_match");
    probe();
    dec(4, 9, 32'h11, 32'h22, 0, 0, 4'h5, 8, 1, 0);
    expect_sig(ID_LU, 1, "lu_rs_match");
    expect_sig(ID_MR, 1, "lu_ex_memren");
    probe();
    tick();
    expect_sig(ID_VAL, 0, "bubble_valid");
    expect_sig(ID_RW, 0, "bubble_regwen");
    expect_sig(ID_MR, 0, "bubble_memren");
    expect_sig(ID_LU, 0, "bubble_lu_drop");
    probe();
    tick();
    expect_sig(ID_VAL, 1, "after_bubble_valid");
    expect_sig(ID_WSEL, 8, "after_bubble_wsel");
    expect_sig(ID_OP, 5, "after_bubble_aluop");
    expect_sig(ID_PA, 32'h11, "after_bubble_portA");
    expect_sig(ID_PB, 32'h22, "after_bubble_portB");
    probe();

    // A value forwarded during a stall survives its producer retiring.
    dec(6, 0, 0, 0, 0, 0, 4'h1, 2, 1, 0);
    tick();
    stall = 1; memwb_regwen = 1; memwb_wsel = 6; memwb_wdat = 32'h99;
    dec(6, 0, 32'h1234, 0, 0, 0, 4'h9, 2, 1, 0);
    expect_sig(ID_PA, 32'h99, "stall_c1_portA");
    probe();
    tick();
    memwb_regwen = 0;
    expect_sig(ID_PA, 32'h99, "stall_c2_portA");
    expect_sig(ID_OP, 1, "stall_hold_aluop");
    expect_sig(ID_VAL, 1, "stall_hold_valid");
    probe();
    tick();
    stall = 0;
    expect_sig(ID_PA, 32'h99, "stall_end_portA");
    probe();
    tick();
    expect_sig(ID_PA, 32'h1234, "post_stall_portA");
    expect_sig(ID_OP, 9, "post_stall_aluop");
    probe();

    // When stall and load_use are both asserted, stall wins. Flush then
    // overrides both.
    dec(1, 2, 0, 0, 0, 0, 4'h0, 4, 1, 1);
    tick();
    dec(4, 0, 0, 0, 0, 0, 4'h6, 5, 1, 0);
    stall = 1;
    expect_sig(ID_LU, 1, "stall_lu_before");
    probe();
    tick();
    expect_sig(ID_VAL, 1, "stall_lu_hold_valid");
    expect_sig(ID_MR, 1, "stall_lu_hold_memren");
    expect_sig(ID_LU, 1, "stall_lu_still");
    probe();
    flush = 1;
    tick();
    expect_sig(ID_VAL, 0, "flush_valid");
    expect_sig(ID_RW, 0, "flush_regwen");
    expect_sig(ID_MR, 0, "flush_memren");
    expect_sig(ID_LU, 0, "flush_lu");
    probe();
    idle();

    // Asynchronous reset in the middle of a cycle.
    dec(1, 0, 32'hDEAD, 0, 0, 0, 4'h7, 3, 1, 0);
    tick();
    expect_sig(ID_PA, 32'hDEAD, "pre_async_portA");
    expect_sig(ID_VAL, 1, "pre_async_valid");
    probe();
    nRST = 0;
    expect_zero("async_reset");
    probe();
    @(negedge CLK);
    nRST = 1;
    idle();
    tick();

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU and drives its portA, portB and aluop inputs.
- Latches decoded operands and control, and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts bubbles.
- Supports stall (hold) and flush (squash) from the hazard/branch logic.

Parameters:
- WORD_W, 32, datapath width (matches word_t).
- REG_W, 5, register-number width.
- OP_W, 4, aluop width (matches aluop_t).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode slot holds a real instruction.
- dec_rs, dec_rt  in  REG_W  source register numbers.
- dec_rdat1, dec_rdat2  in  WORD_W  register-file read data.
- dec_imm  in  WORD_W  extended immediate.
- dec_alusrc  in  1  1 = portB takes the immediate.
- dec_aluop  in  OP_W  ALU operation.
- dec_wsel  in  REG_W  destination register.
- dec_regwen  in  1  instruction writes a register.
- dec_memren  in  1  instruction is a load.
- stall  in  1  hold EX register.
- flush  in  1  squash EX register.
- exmem_regwen  in  1  EX/MEM stage writes a register.
- exmem_wsel  in  REG_W  EX/MEM destination.
- exmem_result  in  WORD_W  EX/MEM value.
- memwb_regwen  in  1  MEM/WB stage writes a register.
- memwb_wsel  in  REG_W  MEM/WB destination.
- memwb_wdat  in  WORD_W  MEM/WB value.
- portA, portB  out  WORD_W  ALU operands.
- aluop  out  OP_W  ALU operation.
- ex_valid  out  1  EX slot valid.
- ex_wsel  out  REG_W  EX destination.
- ex_regwen  out  1  EX writes a register (0 when invalid).
- ex_memren  out  1  EX is a load (0 when invalid).
- load_use  out  1  decode must stall one cycle.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values: all EX register fields are 0. This gives portA=0, portB=0, aluop=4'h0, ex_valid=0, ex_wsel=0, ex_regwen=0, ex_memren=0 and load_use=0.
- Internal EX fields: ex_rs, ex_rt, ex_rdat1, ex_rdat2, ex_imm, ex_alusrc plus the control outputs.
- Register update, per rising edge, first matching rule wins:
  1. flush=1: ex_valid, ex_regwen and ex_memren are cleared; other fields are don't-care but must hold their old values.
  2. stall=1: every field holds, except ex_rdat1 <= fwdA and ex_rdat2 <= fwdB_reg. This refresh keeps a forwarded value from being lost when the producer retires during the stall.
  3. load_use=1: a bubble is inserted (ex_valid, ex_regwen and ex_memren cleared). Decode holds externally.
  4. Otherwise: all dec_* values load. ex_regwen = dec_regwen & dec_valid. ex_memren = dec_memren & dec_valid.
- Forwarding (combinational on the EX register):
  - fwdA = exmem_result if exmem_regwen & exmem_wsel==ex_rs & ex_rs!=0.
  - Else fwdA = memwb_wdat if memwb_regwen & memwb_wsel==ex_rs & ex_rs!=0.
  - Else fwdA = ex_rdat1.
  - fwdB_reg uses the same rules with ex_rt and ex_rdat2.
  - EX/MEM always has priority over MEM/WB. Register 0 is never forwarded.
- Operand outputs:
  - portA = fwdA.
  - portB = ex_imm when ex_alusrc=1, else fwdB_reg.
  - aluop = the EX field.
  - Forwarding is evaluated even when ex_valid=0. The ALU result is ignored downstream.
- load_use = ex_valid & ex_memren & ex_wsel!=0 & dec_valid & (ex_wsel==dec_rs | ex_wsel==dec_rt).
  - This is combinational and independent of dec_alusrc, so it is conservative on rt.
- Simultaneous events:
  - flush with load_use: flush wins.
  - stall with load_use: stall wins, and load_use remains asserted until stall drops.
- Mid-operation nRST: all fields clear immediately, without waiting for a clock edge.

Test Plan:
- Reset then release → all outputs 0. Load dec_rdat1=5, dec_rdat2=7, aluop=ADD, rs=1, rt=2, no forwarding → next cycle portA=5, portB=7, ex_valid=1.
- EX: rs=3, rdat1=1. exmem_regwen=1, exmem_wsel=3, exmem_result=0xAAAA0000. memwb_regwen=1, memwb_wsel=3, memwb_wdat=0x55 → portA=0xAAAA0000. With exmem_wsel=0 instead → portA=0x55.
- EX: rs=0. exmem_regwen=1, exmem_wsel=0, result=0xFFFFFFFF → portA=ex_rdat1 (0). EX with alusrc=1, imm=0x10 and rt forwarding active → portB=0x10.
- EX holds a load with wsel=4. Decode has valid=1, rs=4 → load_use=1. Next edge: ex_valid=0, ex_regwen=0. Decode instruction then loads the following cycle.
- EX: rs=6, rdat1=0. stall=1 for 2 cycles. Cycle 1: memwb_wsel=6, wdat=0x99, regwen=1. Cycle 2: no forwarding → portA=0x99 throughout.
- flush=1 with stall=1 and load_use=1 → ex_valid=0 next edge. nRST pulsed mid-stream with no clock edge → outputs 0 immediately.
